lcd_ctrl: RTL
=============

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 2000000, power-on wait before the first command (20 ms at 100 MHz).
REQ-002 SHALL have parameter E_HIGH_CYCLES, default 24, lcd_e high width per strobe.
REQ-003 SHALL have parameter SETUP_CYCLES, default 4, lcd_rs/lcd_data stable before lcd_e rises and after it falls.
REQ-004 SHALL have parameter CHAR_WAIT_CYCLES, default 5000, idle time after each data write or non-clear command.
REQ-005 SHALL have parameter CLEAR_WAIT_CYCLES, default 200000, idle time after the clear command 0x01.
REQ-006 SHALL have parameter ADDR_SETTLE, default 4, cycles from an addr change to ascii sampling.
REQ-007 clk  input  1  system clock.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 ascii  input  8  character for the current addr, from the display text source.
REQ-010 addr  output  5  character index; bit4 = row, bits3:0 = column.
REQ-011 lcd_data  output  8  LCD data bus.
REQ-012 lcd_rs  output  1  0 = command, 1 = data.
REQ-013 lcd_rw  output  1  tied 0 (write only).
REQ-014 lcd_e  output  1  enable strobe.
REQ-015 frame_done  output  1  one-cycle pulse after the 32nd character of each frame is written.

Function
REQ-016 FSM states: PWR_WAIT, INIT, SET_ROW, FETCH, WRITE.
- Each transition SHALL follow lcd_strobe done.
- PWR_WAIT waits only on its counter.
REQ-017 PWR_WAIT SHALL count POWERUP_CYCLES, then enter INIT.
REQ-018 INIT SHALL issue commands in order 0x38, 0x0C, 0x06, 0x01, then enter SET_ROW with addr=0.
REQ-019 SET_ROW SHALL issue command 0x80 when addr[4]=0 and 0xC0 when addr[4]=1, then enter FETCH.
REQ-020 FETCH SHALL hold addr for ADDR_SETTLE cycles, then latch ascii and enter WRITE.
REQ-021 WRITE SHALL strobe the latched byte with lcd_rs=1.
- Column < 15: increment addr[3:0], go to FETCH.
- Column = 15: go to SET_ROW with addr[4] toggled and addr[3:0]=0.
REQ-022 frame_done SHALL pulse on the cycle WRITE completes with addr=31.
- addr then wraps to 0.
- Refresh repeats indefinitely with no re-init.
REQ-023 Each strobe SHALL be: SETUP_CYCLES with data/rs stable and lcd_e=0; E_HIGH_CYCLES with lcd_e=1; SETUP_CYCLES with lcd_e=0 and data held; then the wait time (CLEAR_WAIT_CYCLES for 0x01, else CHAR_WAIT_CYCLES).
REQ-024 lcd_data and lcd_rs SHALL NOT change while lcd_e=1.
REQ-025 ascii SHALL NOT be sampled outside the FETCH latch cycle; ascii changes at other times have no effect.
REQ-026 Counters SHALL be wide enough for the largest parameter, with no wrap.

Reset
REQ-027 reset SHALL force, on the next edge, from any state including mid-strobe:
- state=PWR_WAIT, all counters=0;
- addr=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0, frame_done=0.
REQ-028 After reset, the full power-up wait and INIT sequence SHALL repeat.

Configuration
REQ-029 Macro LCD_CTRL_4BIT_EN SHALL select the LCD bus mode.
- Defined: 4-bit mode. Each byte is two strobes (high nibble, then low nibble) on lcd_data[7:4]; lcd_data[3:0] driven 0.
- Defined: INIT is preceded by single-nibble strobes 0x3, 0x3, 0x3, 0x2, each followed by CLEAR_WAIT_CYCLES; the function set is 0x28 instead of 0x38.
- Defined: there is no wait between the two nibbles beyond SETUP_CYCLES.
- Undefined: 8-bit mode as in REQ-018..REQ-023.

Structure
REQ-030 Shared package lcd_pkg SHALL hold:
- the FSM state enum;
- command constants CMD_FUNC_8BIT=0x38, CMD_FUNC_4BIT=0x28, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_ROW0=0x80, CMD_ROW1=0xC0.
REQ-031 Sub-module lcd_strobe SHALL implement REQ-023 (and nibble splitting under LCD_CTRL_4BIT_EN).
- Inputs: start, byte, rs, long_wait.
- Outputs: lcd_e, lcd_data, lcd_rs, and a one-cycle done pulse.

Verification (sim parameters POWERUP=20, E_HIGH=3, SETUP=2, CHAR_WAIT=10, CLEAR_WAIT=30, SETTLE=2)
REQ-032 Reset release -> lcd_e stays 0 for 20 cycles; first strobe carries 0x38 with rs=0; then 0x0C, 0x06, 0x01; the gap after 0x01 equals 30 wait cycles.
REQ-033 ascii = 0x41 + addr[3:0] -> row-0 writes are 0x41..0x50 preceded by 0x80; row-1 writes are preceded by 0xC0.
REQ-034 Full frame -> frame_done pulses exactly once per 32 data writes; addr returns to 0; the next command is 0x80 with no re-init.
REQ-035 reset asserted while lcd_e=1 -> lcd_e=0 and addr=0 next cycle; the init sequence restarts from PWR_WAIT.
REQ-036 Checker over all runs -> lcd_data/lcd_rs never change while lcd_e=1; lcd_e high width is exactly 3 cycles.
REQ-037 LCD_CTRL_4BIT_EN defined, ascii=0xA5 -> consecutive strobes carry lcd_data[7:4]=0xA then 0x5; lcd_data[3:0]=0; init begins with nibbles 3, 3, 3, 2, then 0x28.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and command bytes for the HD44780-style LCD refresh controller.
// Bus width is chosen by LCD_CTRL_4BIT_EN (defined: 4-bit nibble bus; undefined: 8-bit bus).
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    SET_ROW,
    FETCH,
    WRITE
  } lcd_state_e;

  typedef enum logic [2:0] {
    STB_IDLE,
    STB_SETUP,
    STB_EHIGH,
    STB_HOLD,
    STB_WAIT
  } stb_phase_e;

  localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ROW0      = 8'h80;
  localparam logic [7:0] CMD_ROW1      = 8'hC0;

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed for a counter running 0 .. n-1.
  function automatic int lcd_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_strobe.sv
// One LCD bus transfer: setup, lcd_e pulse, hold, then the post-command wait; pulses done at the end.
// With LCD_CTRL_4BIT_EN a byte goes out as high nibble then low nibble on lcd_data[7:4].
module lcd_strobe
  import lcd_pkg::*;
#(
  parameter int E_HIGH_CYCLES     = 24,
  parameter int SETUP_CYCLES      = 4,
  parameter int CHAR_WAIT_CYCLES  = 5000,
  parameter int CLEAR_WAIT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       rs,
  input  logic       long_wait,
`ifdef LCD_CTRL_4BIT_EN
  input  logic       nibble_only,
`endif
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       done,
  output stb_phase_e phase_dbg
);

  localparam int CNT_MAX = lcd_max(lcd_max(E_HIGH_CYCLES, SETUP_CYCLES),
                                   lcd_max(CHAR_WAIT_CYCLES, CLEAR_WAIT_CYCLES));
  localparam int CW = lcd_cnt_w(CNT_MAX);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] EHIGH_LAST = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CHAR_LAST  = CW'(CHAR_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYCLES - 1);

  stb_phase_e    phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    data_n;
  logic          rs_n, long_q, long_n, done_n;
`ifdef LCD_CTRL_4BIT_EN
  logic [3:0]    low_q, low_n;
  logic          pend_q, pend_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= STB_IDLE;
      cnt      <= '0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      long_q   <= 1'b0;
      done     <= 1'b0;
`ifdef LCD_CTRL_4BIT_EN
      low_q    <= 4'h0;
      pend_q   <= 1'b0;
`endif
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      lcd_data <= data_n;
      lcd_rs   <= rs_n;
      long_q   <= long_n;
      done     <= done_n;
`ifdef LCD_CTRL_4BIT_EN
      low_q    <= low_n;
      pend_q   <= pend_n;
`endif
    end
  end

  // Bus data and rs only change in IDLE (start) or at the end of HOLD, never while lcd_e is high.
  always_comb begin
    phase_n = phase;
    cnt_n   = cnt + 1'b1;
    data_n  = lcd_data;
    rs_n    = lcd_rs;
    long_n  = long_q;
    done_n  = 1'b0;
`ifdef LCD_CTRL_4BIT_EN
    low_n   = low_q;
    pend_n  = pend_q;
`endif
    case (phase)
      STB_IDLE: begin
        cnt_n = '0;
        if (start) begin
          rs_n    = rs;
          long_n  = long_wait;
          phase_n = STB_SETUP;
`ifdef LCD_CTRL_4BIT_EN
          data_n  = {tx_byte[7:4], 4'h0};
          low_n   = tx_byte[3:0];
          pend_n  = !nibble_only;
`else
          data_n  = tx_byte;
`endif
        end
      end
      STB_SETUP: if (cnt == SETUP_LAST) begin
        cnt_n   = '0;
        phase_n = STB_EHIGH;
      end
      STB_EHIGH: if (cnt == EHIGH_LAST) begin
        cnt_n   = '0;
        phase_n = STB_HOLD;
      end
      STB_HOLD: if (cnt == SETUP_LAST) begin
        cnt_n   = '0;
        phase_n = STB_WAIT;
`ifdef LCD_CTRL_4BIT_EN
        if (pend_q) begin
          pend_n  = 1'b0;
          data_n  = {low_q, 4'h0};
          phase_n = STB_SETUP;
        end
`endif
      end
      STB_WAIT: if (cnt == (long_q ? CLEAR_LAST : CHAR_LAST)) begin
        cnt_n   = '0;
        done_n  = 1'b1;
        phase_n = STB_IDLE;
      end
      default: phase_n = STB_IDLE;
    endcase
  end

  assign lcd_e     = (phase == STB_EHIGH);
  assign phase_dbg = phase;

endmodule

// File: rtl/lcd_ctrl.sv
// Power-up, init and endless 2x16 refresh of a character LCD from an addressed text source.
// Define LCD_CTRL_4BIT_EN for the 4-bit bus (nibble wake-up sequence, function set 0x28).
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES    = 2000000,
  parameter int E_HIGH_CYCLES     = 24,
  parameter int SETUP_CYCLES      = 4,
  parameter int CHAR_WAIT_CYCLES  = 5000,
  parameter int CLEAR_WAIT_CYCLES = 200000,
  parameter int ADDR_SETTLE       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii,
  output logic [4:0] addr,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       frame_done,
  output lcd_state_e state_dbg,
  output stb_phase_e strobe_dbg
);

  localparam int CW = lcd_cnt_w(lcd_max(POWERUP_CYCLES, ADDR_SETTLE));
  localparam logic [CW-1:0] PWR_LAST    = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(ADDR_SETTLE - 1);
`ifdef LCD_CTRL_4BIT_EN
  localparam int IW = 3;
`else
  localparam int IW = 2;
`endif
  localparam logic [IW-1:0] INIT_LAST = '1;

  lcd_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] init_idx, idx_n;
  logic [4:0]    addr_n;
  logic [7:0]    char_q, char_n;
  logic          busy, busy_n, frame_done_n;
  logic          start, stb_done, tx_rs, tx_long;
  logic [7:0]    tx_byte, init_byte;
`ifdef LCD_CTRL_4BIT_EN
  logic          init_nib, tx_nib;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PWR_WAIT;
      cnt        <= '0;
      init_idx   <= '0;
      addr       <= 5'd0;
      char_q     <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      init_idx   <= idx_n;
      addr       <= addr_n;
      char_q     <= char_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    init_byte = CMD_CLEAR;
`ifdef LCD_CTRL_4BIT_EN
    init_nib  = 1'b0;
    case (init_idx)
      3'd0, 3'd1, 3'd2: begin init_byte = 8'h30; init_nib = 1'b1; end
      3'd3:             begin init_byte = 8'h20; init_nib = 1'b1; end
      3'd4:             init_byte = CMD_FUNC_4BIT;
      3'd5:             init_byte = CMD_DISP_ON;
      3'd6:             init_byte = CMD_ENTRY;
      default:          init_byte = CMD_CLEAR;
    endcase
`else
    case (init_idx)
      2'd0:    init_byte = CMD_FUNC_8BIT;
      2'd1:    init_byte = CMD_DISP_ON;
      2'd2:    init_byte = CMD_ENTRY;
      default: init_byte = CMD_CLEAR;
    endcase
`endif
  end

  // Strobing states raise start once (busy guards re-issue) and advance only on done.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = init_idx;
    addr_n       = addr;
    char_n       = char_q;
    busy_n       = busy;
    frame_done_n = 1'b0;
    start        = 1'b0;
    tx_byte      = 8'h00;
    tx_rs        = 1'b0;
`ifdef LCD_CTRL_4BIT_EN
    tx_nib       = 1'b0;
`endif
    case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = INIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      INIT: begin
        tx_byte = init_byte;
`ifdef LCD_CTRL_4BIT_EN
        tx_nib  = init_nib;
`endif
        if (!busy) begin
          start  = 1'b1;
          busy_n = 1'b1;
        end else if (stb_done) begin
          busy_n = 1'b0;
          if (init_idx == INIT_LAST) begin
            addr_n  = 5'd0;
            state_n = SET_ROW;
          end else begin
            idx_n = init_idx + 1'b1;
          end
        end
      end
      SET_ROW: begin
        tx_byte = addr[4] ? CMD_ROW1 : CMD_ROW0;
        if (!busy) begin
          start  = 1'b1;
          busy_n = 1'b1;
        end else if (stb_done) begin
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (cnt == SETTLE_LAST) begin
          char_n  = ascii;
          cnt_n   = '0;
          state_n = WRITE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WRITE: begin
        tx_byte = char_q;
        tx_rs   = 1'b1;
        if (!busy) begin
          start  = 1'b1;
          busy_n = 1'b1;
        end else if (stb_done) begin
          busy_n       = 1'b0;
          frame_done_n = (addr == 5'd31);
          if (addr[3:0] == 4'hF) begin
            addr_n  = {~addr[4], 4'h0};
            state_n = SET_ROW;
          end else begin
            addr_n  = addr + 5'd1;
            cnt_n   = '0;
            state_n = FETCH;
          end
        end
      end
      default: state_n = PWR_WAIT;
    endcase
  end

`ifdef LCD_CTRL_4BIT_EN
  assign tx_long = tx_nib || (!tx_rs && tx_byte == CMD_CLEAR);
`else
  assign tx_long = !tx_rs && tx_byte == CMD_CLEAR;
`endif

  lcd_strobe #(
    .E_HIGH_CYCLES    (E_HIGH_CYCLES),
    .SETUP_CYCLES     (SETUP_CYCLES),
    .CHAR_WAIT_CYCLES (CHAR_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tx_byte    (tx_byte),
    .rs         (tx_rs),
    .long_wait  (tx_long),
`ifdef LCD_CTRL_4BIT_EN
    .nibble_only(tx_nib),
`endif
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .done       (stb_done),
    .phase_dbg  (strobe_dbg)
  );

  assign lcd_rw    = 1'b0;
  assign state_dbg = state;

endmodule
